// File: rtl/fdiv_mantissa_seq_pkg.sv
// Shared definitions for the sequential restoring mantissa divider.
// Width defaults, FSM encoding and the divide-by-zero quotient pattern.
package fdiv_mantissa_seq_pkg;

  localparam int MW_DEF = 24;
  localparam int QW_DEF = 26;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Sliced down to QW by users; QW is bounded by the 5-bit iteration counter.
  localparam logic [31:0] DZ_QUOT_ALL = 32'hFFFF_FFFF;

endpackage

// File: rtl/fdiv_mantissa_seq_if.sv
// Handshake and operand/result bundle between the divide-path pipeline
// (master) and the mantissa divider (slave).
interface fdiv_mantissa_seq_if
  import fdiv_mantissa_seq_pkg::*;
#(
  parameter int MW = MW_DEF,
  parameter int QW = QW_DEF
);

  logic          start;
  logic [MW-1:0] a;
  logic [MW-1:0] b;
  logic          busy;
  logic          done;
  logic [QW-1:0] q;
  logic          sticky;
  logic          dz;

  modport master (
    output start, a, b,
    input  busy, done, q, sticky, dz
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, sticky, dz
  );

endinterface

// File: rtl/fdiv_mantissa_seq_restore_step.sv
// One combinational restoring-division step: trial subtract, select, shift.
// Kept standalone so radix-4 or square-root units can reuse it.
module fdiv_restore_step
  import fdiv_mantissa_seq_pkg::*;
#(
  parameter int MW = MW_DEF
) (
  input  logic [MW:0]   r_i,
  input  logic [MW-1:0] d_i,
  output logic [MW:0]   r_o,
  output logic          bit_o
);

  logic [MW+1:0] diff;

  always_comb begin
    diff  = {1'b0, r_i} - {2'b00, d_i};
    bit_o = ~diff[MW+1];
    // A non-negative difference is below d, so the shifted value still fits MW+1 bits.
    if (bit_o) begin
      r_o = diff[MW:0] << 1;
    end else begin
      r_o = r_i << 1;
    end
  end

endmodule

// File: rtl/fdiv_mantissa_seq.sv
// Sequential restoring mantissa divider, one quotient bit per cycle.
// Define FDIV_STICKY_EN to compute sticky from the final remainder; otherwise sticky is 0.
module fdiv_mantissa_seq
  import fdiv_mantissa_seq_pkg::*;
#(
  parameter int MW = MW_DEF,
  parameter int QW = QW_DEF
) (
  input  logic              clk,
  input  logic              clrn,
  fdiv_mantissa_seq_if.slave bus
);

  state_e        state_q, state_d;
  logic [MW:0]   r_q, r_d;
  logic [MW-1:0] d_q, d_d;
  logic [QW-1:0] qs_q, qs_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [QW-1:0] q_q, q_d;
  logic          sticky_q, sticky_d;
  logic          dz_q, dz_d;
  logic          done_q, done_d;

  logic [MW:0]   stepR;
  logic          stepBit;
  logic [QW-1:0] qsNext;

  fdiv_restore_step #(.MW(MW)) u_step (
    .r_i   (r_q),
    .d_i   (d_q),
    .r_o   (stepR),
    .bit_o (stepBit)
  );

  assign qsNext = {qs_q[QW-2:0], stepBit};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= IDLE;
      r_q      <= '0;
      d_q      <= '0;
      qs_q     <= '0;
      cnt_q    <= '0;
      q_q      <= '0;
      sticky_q <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      d_q      <= d_d;
      qs_q     <= qs_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      sticky_q <= sticky_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    d_d      = d_q;
    qs_d     = qs_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    sticky_d = sticky_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // A zero divisor finishes immediately without entering the iteration.
          if (bus.b == '0) begin
            q_d      = DZ_QUOT_ALL[QW-1:0];
            sticky_d = 1'b0;
            dz_d     = 1'b1;
            done_d   = 1'b1;
          end else begin
            r_d     = {1'b0, bus.a};
            d_d     = bus.b;
            qs_d    = '0;
            cnt_d   = 5'(QW - 1);
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        r_d  = stepR;
        qs_d = qsNext;
        if (cnt_q == 5'd0) begin
          q_d      = qsNext;
`ifdef FDIV_STICKY_EN
          sticky_d = |stepR;
`else
          sticky_d = 1'b0;
`endif
          dz_d     = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q == BUSY);
  assign bus.done   = done_q;
  assign bus.q      = q_q;
  assign bus.sticky = sticky_q;
  assign bus.dz     = dz_q;

endmodule

// File: tb/tb_fdiv_mantissa_seq.sv
// Directed self-checking bench for fdiv_mantissa_seq (honours FDIV_STICKY_EN).
module tb_fdiv_mantissa_seq;

  logic clk;
  logic clrn;
  int   testsRun  = 0;
  int   failCount = 0;

  fdiv_mantissa_seq_if #(.MW(24), .QW(26)) bus ();

  fdiv_mantissa_seq #(.MW(24), .QW(26)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the edge that sampled start.
  task automatic applyStimulus(input logic [23:0] av, input logic [23:0] bv);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 24'($urandom);
    bus.b     = 24'($urandom);
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic runCase(input string tag, input logic [23:0] av, input logic [23:0] bv,
                         input logic [25:0] expQ, input logic expS, input logic expDz,
                         input int expLat);
    int lat;
    applyStimulus(av, bv);
    checkOutput({tag, ".busyAfterStart"}, bus.busy, (expLat != 0));
    waitDone(lat);
    checkOutput({tag, ".latency"}, lat, expLat);
    checkOutput({tag, ".q"}, bus.q, expQ);
    checkOutput({tag, ".sticky"}, bus.sticky, expS);
    checkOutput({tag, ".dz"}, bus.dz, expDz);
    checkOutput({tag, ".busyAtDone"}, bus.busy, 1'b0);
    @(posedge clk);
    #1;
    checkOutput({tag, ".donePulse"}, bus.done, 1'b0);
    checkOutput({tag, ".qHold"}, bus.q, expQ);
  endtask

  initial begin
    int   lat;
    int   doneEdge;
    int   doneSeen;
    logic expSticky3;
`ifdef FDIV_STICKY_EN
    expSticky3 = 1'b1;
`else
    expSticky3 = 1'b0;
`endif

    clrn      = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.busy", bus.busy, 1'b0);
    checkOutput("reset.done", bus.done, 1'b0);
    checkOutput("reset.q", bus.q, 26'h0);
    checkOutput("reset.sticky", bus.sticky, 1'b0);
    checkOutput("reset.dz", bus.dz, 1'b0);
    clrn = 1'b1;
    @(posedge clk);
    #1;

    runCase("oneOverOne", 24'h800000, 24'h800000, 26'h2000000, 1'b0, 1'b0, 26);
    runCase("threeHalves", 24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0, 26);
    runCase("twoThirds", 24'h800000, 24'hC00000, 26'h1555555, expSticky3, 1'b0, 26);

    // Back-to-back: second start issued while done of the first is visible.
    applyStimulus(24'hFFFFFF, 24'h800000);
    waitDone(lat);
    checkOutput("maxA.latency", lat, 26);
    checkOutput("maxA.q", bus.q, 26'h3FFFFFC);
    checkOutput("maxA.sticky", bus.sticky, 1'b0);
    applyStimulus(24'hFFFFFF, 24'hFFFFFF);
    checkOutput("b2b.busy", bus.busy, 1'b1);
    waitDone(lat);
    checkOutput("b2b.latency", lat, 26);
    checkOutput("b2b.q", bus.q, 26'h2000000);
    checkOutput("b2b.sticky", bus.sticky, 1'b0);
    @(posedge clk);
    #1;

    runCase("divZero", 24'hC00000, 24'h000000, 26'h3FFFFFF, 1'b0, 1'b1, 0);
    checkOutput("divZero.busyAfter", bus.busy, 1'b0);

    // Starts issued mid-operation must not disturb the running divide.
    applyStimulus(24'h800000, 24'hC00000);
    doneEdge = -1;
    for (int i = 1; i <= 40 && doneEdge < 0; i++) begin
      bus.start = (i == 5 || i == 12);
      bus.a     = 24'hFFFFFF;
      bus.b     = (i == 12) ? 24'h000000 : 24'h800000;
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) doneEdge = i;
    end
    bus.start = 1'b0;
    checkOutput("ignoreStart.doneEdge", doneEdge, 26);
    checkOutput("ignoreStart.q", bus.q, 26'h1555555);
    checkOutput("ignoreStart.sticky", bus.sticky, expSticky3);
    checkOutput("ignoreStart.dz", bus.dz, 1'b0);
    @(posedge clk);
    #1;

    // Reset during an operation aborts it with no completion.
    applyStimulus(24'hC00000, 24'h800000);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    clrn = 1'b0;
    #1;
    checkOutput("abort.busy", bus.busy, 1'b0);
    checkOutput("abort.done", bus.done, 1'b0);
    checkOutput("abort.q", bus.q, 26'h0);
    checkOutput("abort.sticky", bus.sticky, 1'b0);
    checkOutput("abort.dz", bus.dz, 1'b0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    doneSeen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) doneSeen++;
    end
    checkOutput("abort.noDone", doneSeen, 0);
    runCase("afterAbort", 24'hFFFFFF, 24'hFFFFFF, 26'h2000000, 1'b0, 1'b0, 26);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
